prog_rom_loader: RTL
====================

# prog_rom_loader

Program memory for the UART-bootable single-cycle MIPS core: holds the instruction ROM image, serves the fetch stage's word address with registered read data, and reloads the image from the UART byte stream on demand. It sits directly upstream of the instruction-fetch stage. It drives `instruction_o` into the fetch stage's instruction input and `cpu_hold` into the CPU reset/stall logic. It takes the fetch stage's 14-bit word address on `rom_adr_i`.

## Interface
- `ADDR_W`, default 14: word-address width.
- `DEPTH`, default 16384: number of words; must equal 2^ADDR_W.
- `TIMEOUT_CYCLES`, default 2_000_000: inter-byte gap limit in clock cycles.

- `clock` in 1: system clock; all logic runs on posedge.
- `reset` in 1: synchronous, active-high.
- `rom_adr_i` in ADDR_W: word address from the fetch stage.
- `instruction_o` out 32: registered memory word at `rom_adr_i`.
- `rx_valid` in 1: one-cycle strobe; `rx_byte` is valid.
- `rx_byte` in 8: received UART byte.
- `boot_mode` in 1: load-request switch; its rising edge starts a load.
- `cpu_hold` out 1: 1 while loading or in error; the CPU is held in reset.
- `load_done` out 1: one-cycle pulse when a load completes.
- `load_error` out 1: level; 1 while in ERR.
- `words_loaded` out 16: words written in the current or last load.

## Operation
- Frame format:
  - 2-byte big-endian word count N.
  - Then N words of 4 bytes each, most-significant byte first.
  - Word k is written to address k, for k = 0..N-1.
- States are RUN, LEN_HI, LEN_LO, DATA and ERR.
- RUN:
  - `cpu_hold`=0 and `rx_valid` is ignored.
  - A `boot_mode` rising edge (registered `boot_mode` was 0, current value is 1) moves to LEN_HI and clears `words_loaded` and the byte index.
- LEN_HI: on `rx_valid`, latch N[15:8] and go to LEN_LO.
- LEN_LO: on `rx_valid`, latch N[7:0], then:
  - N=0: go to RUN and pulse `load_done`.
  - N>DEPTH: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - The 2-bit byte index collects bytes 0–2 into a shift register.
  - On byte 3, write {b0,b1,b2,`rx_byte`} to mem[`words_loaded`] and increment `words_loaded`.
  - If the incremented value equals N, go to RUN and pulse `load_done`.
- ERR:
  - `cpu_hold`=1 and `load_error`=1.
  - Exits only on a `boot_mode` rising edge (to LEN_HI, clearing `load_error`) or on `reset`.
- `cpu_hold` = 1 in every state except RUN.
- Read port:
  - `instruction_o` <= mem[`rom_adr_i`] every posedge, in all states.
  - When a read and a write hit the same address on the same edge, the read returns the old data.
- Reset:
  - `instruction_o` 0, `cpu_hold` 0, `load_done` 0, `load_error` 0, `words_loaded` 0.
  - State goes to RUN and the `boot_mode` register is loaded with current `boot_mode`. A switch already high at reset therefore does not trigger a load.
  - Memory contents are not cleared.
- Reset mid-load: the load is abandoned. Words already written stay in memory and the CPU resumes from them.

## Timing
- Read latency is 1 cycle: an address presented before posedge t appears on `instruction_o` after t.
  - The fetch stage updates PC on negedge, so data is valid by the following negedge.
- Bytes are captured on the posedge where `rx_valid`=1. At most one byte per cycle is accepted, and back-to-back strobes are legal.
- The write to memory, the `words_loaded` increment, the RUN transition and the `load_done` assertion all occur on the edge that captures the final byte.
  - `load_done` is high for exactly the following cycle.
  - `cpu_hold` falls on that same edge.
- State changes on a `boot_mode` rising edge take effect one cycle after the edge is sampled.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A counter runs in LEN_LO and DATA. It clears on every accepted byte and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`, the block enters ERR on that edge.
  - LEN_HI never times out.
- `LOADER_TIMEOUT_EN` undefined:
  - No counter exists.
  - A partial frame waits indefinitely, and only `reset` or a `boot_mode` rising edge recovers it.

## Test plan
- **Normal load:** reset, raise `boot_mode`, send 00 02 20 08 00 05 AC 08 00 00.
  - `load_done` pulses 1 cycle after the last byte, `cpu_hold` 1->0, `words_loaded`=2.
  - `rom_adr_i`=1 gives `instruction_o`=0xAC080000 after the next posedge, and `rom_adr_i`=0 gives 0x20080005.
- **Zero count:** send 00 00. Expect immediate RUN, a `load_done` pulse, no memory writes, and `words_loaded`=0.
- **Oversize:** send 40 01 (N=16385). Expect ERR with `load_error`=1 and `cpu_hold`=1. A `boot_mode` fall then rise returns to LEN_HI with `load_error`=0.
- **Timeout:** set `TIMEOUT_CYCLES`=100, then send 00 01 20 08 followed by silence.
  - With `LOADER_TIMEOUT_EN`: ERR exactly 100 cycles after the last byte.
  - Without it: the block is still in DATA after 10000 cycles.
- **Reset mid-load:** assert `reset` after 1.5 words.
  - All outputs take their reset values.
  - mem[0] keeps the loaded word.
  - `boot_mode` held high does not restart the load.
- **Idle and collision behaviour:**
  - `rx_valid` strobes in RUN leave memory, state and `words_loaded` unchanged.
  - A read of address 0 on the same edge as its write returns the pre-write value.

Source files
------------

// File: rtl/prog_rom_loader_if.sv
// ---------------------------------------------------------------------------
// prog_rom_loader_if
// Bundles the signals between the program ROM loader and its neighbours:
//   fetch side : rom_adr_i (word address in), instruction_o (read data out)
//   UART side  : rx_valid / rx_byte (one-cycle byte strobe)
//   control    : boot_mode (load request switch), cpu_hold, load_done,
//                load_error, words_loaded
// Modports:
//   master - the surrounding system (fetch stage, UART, switch, CPU control)
//   slave  - the loader itself
// ---------------------------------------------------------------------------
interface prog_rom_loader_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] rom_adr_i;
  logic [31:0]       instruction_o;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              boot_mode;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [15:0]       words_loaded;

  modport master (
    output rom_adr_i, rx_valid, rx_byte, boot_mode,
    input  instruction_o, cpu_hold, load_done, load_error, words_loaded
  );

  modport slave (
    input  rom_adr_i, rx_valid, rx_byte, boot_mode,
    output instruction_o, cpu_hold, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/prog_rom_loader.sv
// ---------------------------------------------------------------------------
// prog_rom_loader
// Instruction memory for the UART-bootable MIPS core. Serves the fetch
// stage with a registered (1-cycle) read and reloads its contents from a
// UART byte stream framed as: 2-byte big-endian word count N, then N
// big-endian 32-bit words written to addresses 0..N-1.
//
// Ports:
//   clock  - system clock, posedge
//   reset  - synchronous, active-high
//   bus    - prog_rom_loader_if.slave (fetch address/data, UART bytes,
//            boot_mode switch, cpu_hold / load_done / load_error /
//            words_loaded status)
//
// Parameters:
//   ADDR_W         - word address width
//   DEPTH          - number of words, must equal 2**ADDR_W
//   TIMEOUT_CYCLES - inter-byte gap limit (only with LOADER_TIMEOUT_EN)
//
// Build option:
//   LOADER_TIMEOUT_EN - when defined, a stalled frame in LEN_LO or DATA
//                       falls into ERR after TIMEOUT_CYCLES idle cycles.
//                       When undefined, a partial frame waits forever.
// ---------------------------------------------------------------------------
module prog_rom_loader #(
  parameter int ADDR_W         = 14,
  parameter int DEPTH          = 16384,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input logic              clock,
  input logic              reset,
  prog_rom_loader_if.slave bus
);

  // Elaboration-time sanity check on the configuration.
  if (DEPTH != (1 << ADDR_W) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("prog_rom_loader: DEPTH must be 2**ADDR_W and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    RUN,
    LEN_HI,
    LEN_LO,
    DATA,
    ERR
  } state_t;

  state_t       state_q, state_d;
  logic         boot_q;
  logic [15:0]  len_q, len_d;
  logic [15:0]  words_q, words_d;
  logic [1:0]   idx_q, idx_d;
  logic [23:0]  shift_q, shift_d;
  logic         done_q, done_d;
  logic [31:0]  instr_q;

  logic         boot_rise;
  logic         to_expire;
  logic [15:0]  n_rx;
  logic [15:0]  words_inc;
  logic         mem_we;
  logic [31:0]  mem_wdata;

  logic [31:0]  mem [DEPTH];

  assign boot_rise = bus.boot_mode & ~boot_q;
  // Full word count as it will be once the low byte on the bus is latched.
  assign n_rx      = {len_q[15:8], bus.rx_byte};
  assign words_inc = words_q + 16'd1;
  assign mem_wdata = {shift_q, bus.rx_byte};

`ifdef LOADER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);

  logic [31:0] to_cnt_q, to_cnt_d;

  // Counts idle cycles while a frame is in progress past the first byte.
  // Any accepted byte, or any other state, holds it at zero.
  always_comb begin
    to_cnt_d  = '0;
    to_expire = 1'b0;
    if ((state_q == LEN_LO || state_q == DATA) && !bus.rx_valid) begin
      to_cnt_d  = to_cnt_q + 32'd1;
      to_expire = (to_cnt_d == TIMEOUT_U);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  // Next-state logic. A boot_mode rising edge restarts the load from any
  // state, so a stuck or broken frame can always be recovered.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;

    if (boot_rise) begin
      state_d = LEN_HI;
      words_d = '0;
      idx_d   = '0;
    end else if (to_expire) begin
      state_d = ERR;
    end else begin
      case (state_q)
        RUN: begin
          // Bytes arriving while the CPU runs are ignored.
        end
        LEN_HI: begin
          if (bus.rx_valid) begin
            len_d[15:8] = bus.rx_byte;
            state_d     = LEN_LO;
          end
        end
        LEN_LO: begin
          if (bus.rx_valid) begin
            len_d[7:0] = bus.rx_byte;
            if (n_rx == 16'd0) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else if ({16'd0, n_rx} > DEPTH_U) begin
              state_d = ERR;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              mem_we  = 1'b1;
              words_d = words_inc;
              if (words_inc == len_q) begin
                state_d = RUN;
                done_d  = 1'b1;
              end
            end else begin
              shift_d = {shift_q[15:0], bus.rx_byte};
            end
          end
        end
        ERR: begin
          // Left only via boot_mode rising edge or reset.
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      // Loading the current switch value means a switch already high at
      // reset does not look like a rising edge afterwards.
      boot_q  <= bus.boot_mode;
      len_q   <= '0;
      words_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= bus.boot_mode;
      len_q   <= len_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  // Memory write port. Contents survive reset; a write is suppressed on a
  // reset edge so an abandoned load cannot sneak in one more word.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[words_q[ADDR_W-1:0]] <= mem_wdata;
    end
  end

  // Registered read port; same-edge read of a written address sees the
  // old contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
    end else begin
      instr_q <= mem[bus.rom_adr_i];
    end
  end

  assign bus.instruction_o = instr_q;
  assign bus.cpu_hold      = (state_q != RUN);
  assign bus.load_error    = (state_q == ERR);
  assign bus.load_done     = done_q;
  assign bus.words_loaded  = words_q;

endmodule
